hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It watches the ID, EX and MEM stages and drives the hold and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazards:
- load-use hazards, by inserting a bubble;
- branch mispredicts, by squashing the younger stages;
- data-memory wait states, by freezing the pipeline, with a timeout.

A timed-out memory access drives the core into a sticky fault state.

## Interface
Parameters:
- MEM_TIMEOUT, default 16: consecutive not-ready cycles allowed before a fault. Legal range 1..255.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- id_rs1_addr_i  in  5  rs1 index of the instruction in ID
- id_rs2_addr_i  in  5  rs2 index of the instruction in ID
- id_rs1_used_i  in  1  ID instruction reads rs1
- id_rs2_used_i  in  1  ID instruction reads rs2
- ex_reg_wr_addr_i  in  5  destination register of the instruction in EX
- ex_reg_wr_sig_i  in  1  EX instruction writes the register file
- ex_is_load_i  in  1  EX instruction is a load (data_dest == MEM)
- br_mispredict_i  in  1  branch resolved in EX disagrees with br_pred
- mem_req_i  in  1  MEM stage issues a data-memory access
- mem_ready_i  in  1  data memory completes the access this cycle
- pc_hold_o  out  1  PC keeps its value
- pc_redirect_en_o  out  1  PC loads the branch-correction target
- if_id_hold_o  out  1  IF/ID keeps its contents
- if_id_flush_o  out  1  IF/ID loads a NOP
- id_ex_flush_o  out  1  ID/EX loads a bubble (drives its flush_i)
- id_ex_hold_o  out  1  ID/EX keeps its contents
- ex_mem_hold_o  out  1  EX/MEM keeps its contents
- mem_wb_bubble_o  out  1  MEM/WB loads a bubble
- fault_o  out  1  sticky memory-timeout fault
- state_o  out  2  current FSM state, for debug

## Operation
FSM states: RUN=0, MEM_WAIT=1, FLUSH_PEND=2, FAULT=3.

Combinational hazard terms:
- load_use = ex_is_load_i & ex_reg_wr_sig_i & (ex_reg_wr_addr_i != 0) & ((id_rs1_used_i & rs1 match) | (id_rs2_used_i & rs2 match)).
- mem_stall = mem_req_i & !mem_ready_i.

Priority, highest first: FAULT > mem_stall > mispredict > load_use.

Behaviour by state:
- RUN:
  - If mem_stall: assert all holds (pc, if_id, id_ex, ex_mem) and mem_wb_bubble_o. Clear wait_cnt to 1. Go to MEM_WAIT.
  - If br_mispredict_i is also high in that cycle, go to FLUSH_PEND instead, with wait_cnt=1.
  - Else if mispredict: assert pc_redirect_en_o, if_id_flush_o and id_ex_flush_o; no holds.
  - Else if load_use: assert pc_hold_o, if_id_hold_o and id_ex_flush_o.
- MEM_WAIT / FLUSH_PEND:
  - While mem_stall: hold all stages, assert the MEM/WB bubble, increment wait_cnt.
  - A mispredict seen in MEM_WAIT moves the FSM to FLUSH_PEND.
  - No redirect and no load-use action is taken while waiting.
  - On the cycle mem_ready_i rises, holds drop.
    - From FLUSH_PEND, the flush outputs and pc_redirect_en_o are asserted in that same cycle.
    - The FSM returns to RUN.
  - If mem_req_i drops without ready, the access is abandoned: release the holds and return to RUN.
- Timeout: when wait_cnt == MEM_TIMEOUT and mem_stall is still true, go to FAULT.
- FAULT: all holds asserted, mem_wb_bubble_o=1, fault_o=1. Only reset exits this state.
- wait_cnt is 8 bits and saturates at 255.
- Holds and flushes are never asserted on the same register in the same cycle. Hold wins.

## Timing
- All stage controls are Mealy outputs, valid in the same cycle as their inputs; the pipeline registers act on the next clk edge.
- Load-use: exactly one bubble cycle, then the dependent instruction proceeds (the load has moved to MEM).
- Mispredict: one-cycle flush pulse in RUN. From FLUSH_PEND, the flush is delayed until the release cycle.
- Reset, sampled at posedge clk:
  - state=RUN, wait_cnt=0, fault_o=0, state_o=0.
  - While reset is high, all outputs are 0 except if_id_flush_o=1 and id_ex_flush_o=1.
- Reset during MEM_WAIT or FAULT: back to RUN on the next edge, and any pending flush is discarded.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds 32-bit saturating counters and two output ports.
  - stall_cycles_o (32 bits) counts every cycle any hold is asserted.
  - flush_count_o (32 bits) counts every mispredict flush actually applied.
  - Both counters clear on reset.
- Undefined: the ports still exist and are tied to 0; no counter flops are built.

## Structure
- FSM state encodings and MEM_TIMEOUT's default go in the shared parameters.vh, next to ALU_ADD/ALU, so the debug tooling can decode state_o.
- One sub-module: mem_wait_timer. It holds the wait_cnt counter with clear, enable and saturate, plus the timeout compare, and outputs a single expired flag.

## Test plan
- Load-use: load writes x5 in EX; ID reads rs1=5 -> one cycle with pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1, then normal flow. Same case with rd=x0 -> no stall.
- Mispredict in RUN -> single cycle of pc_redirect_en_o=1, if_id_flush_o=1, id_ex_flush_o=1; a coincident load_use is ignored.
- Memory wait: mem_req_i=1, mem_ready_i low for 3 cycles -> holds high for 3 cycles, released on the ready cycle, state_o returns to 0.
- Mispredict during MEM_WAIT -> state_o=2; the flush and redirect fire only in the mem_ready_i cycle.
- MEM_TIMEOUT=4 with ready never asserted -> fault_o=1 after the 4th wait cycle and stays high; reset asserted -> fault_o=0 and state_o=0 on the next edge.
- With HAZARD_PERF_CNT_EN: two load-use stalls plus a 3-cycle wait -> stall_cycles_o=5. One mispredict -> flush_count_o=1.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings (decoded by
// debug tooling from state_o), timeout default and the stage-control bundle.
package hazard_ctrl_pkg;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT   = 2'd1;
    localparam logic [1:0] ST_FLUSH_PEND = 2'd2;
    localparam logic [1:0] ST_FAULT      = 2'd3;

    localparam int MEM_TIMEOUT_DEFAULT = 16;
    localparam int WAIT_CNT_W          = 8;

    typedef struct packed {
        logic pc_hold;
        logic pc_redirect_en;
        logic if_id_hold;
        logic if_id_flush;
        logic id_ex_flush;
        logic id_ex_hold;
        logic ex_mem_hold;
        logic mem_wb_bubble;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_IDLE = '0;

    function automatic stage_ctrl_t ctrl_freeze();
        stage_ctrl_t c;
        c               = CTRL_IDLE;
        c.pc_hold       = 1'b1;
        c.if_id_hold    = 1'b1;
        c.id_ex_hold    = 1'b1;
        c.ex_mem_hold   = 1'b1;
        c.mem_wb_bubble = 1'b1;
        return c;
    endfunction

    function automatic stage_ctrl_t ctrl_redirect();
        stage_ctrl_t c;
        c                = CTRL_IDLE;
        c.pc_redirect_en = 1'b1;
        c.if_id_flush    = 1'b1;
        c.id_ex_flush    = 1'b1;
        return c;
    endfunction

    function automatic stage_ctrl_t ctrl_load_use();
        stage_ctrl_t c;
        c             = CTRL_IDLE;
        c.pc_hold     = 1'b1;
        c.if_id_hold  = 1'b1;
        c.id_ex_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mem_wait_timer.sv
// Data-memory wait-state counter: clear-to-1, saturating increment, and the
// timeout compare reduced to a single expired flag.
module mem_wait_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WAIT_CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(TIMEOUT);

    logic [WAIT_CNT_W-1:0] wait_cnt;

    // The clearing cycle is itself the first stalled cycle, hence the load of 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= WAIT_CNT_W'(1);
        end else if (en && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
        end
    end

    assign expired = (wait_cnt == TIMEOUT_CNT);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, mispredict squash and memory-wait
// freeze with timeout fault. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs1_used_i,
    input  logic        id_rs2_used_i,
    input  logic [4:0]  ex_reg_wr_addr_i,
    input  logic        ex_reg_wr_sig_i,
    input  logic        ex_is_load_i,
    input  logic        br_mispredict_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    output logic        pc_hold_o,
    output logic        pc_redirect_en_o,
    output logic        if_id_hold_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        id_ex_hold_o,
    output logic        ex_mem_hold_o,
    output logic        mem_wb_bubble_o,
    output logic        fault_o,
    output logic [1:0]  state_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_count_o
);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        load_use;
    logic        mem_stall;
    logic        expired;
    logic        timer_clr;
    logic        timer_en;
    stage_ctrl_t ctrl;
    stage_ctrl_t ctrl_out;

    assign load_use = ex_is_load_i & ex_reg_wr_sig_i & (ex_reg_wr_addr_i != 5'd0) &
                      ((id_rs1_used_i & (id_rs1_addr_i == ex_reg_wr_addr_i)) |
                       (id_rs2_used_i & (id_rs2_addr_i == ex_reg_wr_addr_i)));
    assign mem_stall = mem_req_i & ~mem_ready_i;

    mem_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    always_comb begin
        state_nxt = state;
        ctrl      = CTRL_IDLE;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    ctrl      = ctrl_freeze();
                    timer_clr = 1'b1;
                    state_nxt = br_mispredict_i ? ST_FLUSH_PEND : ST_MEM_WAIT;
                end else if (br_mispredict_i) begin
                    ctrl = ctrl_redirect();
                end else if (load_use) begin
                    ctrl = ctrl_load_use();
                end
            end
            ST_MEM_WAIT, ST_FLUSH_PEND: begin
                if (mem_stall) begin
                    ctrl     = ctrl_freeze();
                    timer_en = 1'b1;
                    if (expired) begin
                        state_nxt = ST_FAULT;
                    end else if (br_mispredict_i) begin
                        state_nxt = ST_FLUSH_PEND;
                    end
                end else begin
                    // Release (ready or abandoned access): the pipeline moves this
                    // cycle, so a pending flush or a live hazard must act now.
                    state_nxt = ST_RUN;
                    if ((state == ST_FLUSH_PEND) || br_mispredict_i) begin
                        ctrl = ctrl_redirect();
                    end else if (load_use) begin
                        ctrl = ctrl_load_use();
                    end
                end
            end
            default: begin
                ctrl = ctrl_freeze();
            end
        endcase
    end

    always_comb begin
        ctrl_out             = ctrl;
        ctrl_out.if_id_flush = ctrl.if_id_flush & ~ctrl.if_id_hold;
        ctrl_out.id_ex_flush = ctrl.id_ex_flush & ~ctrl.id_ex_hold;
        if (reset) begin
            ctrl_out             = CTRL_IDLE;
            ctrl_out.if_id_flush = 1'b1;
            ctrl_out.id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign pc_hold_o        = ctrl_out.pc_hold;
    assign pc_redirect_en_o = ctrl_out.pc_redirect_en;
    assign if_id_hold_o     = ctrl_out.if_id_hold;
    assign if_id_flush_o    = ctrl_out.if_id_flush;
    assign id_ex_flush_o    = ctrl_out.id_ex_flush;
    assign id_ex_hold_o     = ctrl_out.id_ex_hold;
    assign ex_mem_hold_o    = ctrl_out.ex_mem_hold;
    assign mem_wb_bubble_o  = ctrl_out.mem_wb_bubble;
    assign fault_o          = ~reset & (state == ST_FAULT);
    assign state_o          = reset ? ST_RUN : state;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic        any_hold;

    assign any_hold = ctrl_out.pc_hold | ctrl_out.if_id_hold |
                      ctrl_out.id_ex_hold | ctrl_out.ex_mem_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (any_hold && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (ctrl_out.pc_redirect_en && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cnt;
    assign flush_count_o  = flush_cnt;
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MEM_TIMEOUT=4): vector table plus
// hand-written timeout and perf-counter sequences, checked through a scoreboard.
module tb_hazard_ctrl;

    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_RST  = 8'b0001_1000;
    localparam logic [7:0] C_LU   = 8'b1010_1000;
    localparam logic [7:0] C_MIS  = 8'b0101_1000;
    localparam logic [7:0] C_HOLD = 8'b1010_0111;
    localparam logic [7:0] HOLD_MASK = 8'b1010_0110;

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic       rs1u;
        logic [4:0] rs2;
        logic       rs2u;
        logic [4:0] exwa;
        logic       exwr;
        logic       exld;
        logic       mis;
        logic       req;
        logic       rdy;
        logic [7:0] ctrl;
        logic [1:0] st;
        logic       fault;
    } vec_t;

    typedef struct {
        logic [10:0] exp;
        int          idx;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, ex_reg_wr_addr_i;
    logic        id_rs1_used_i, id_rs2_used_i, ex_reg_wr_sig_i, ex_is_load_i;
    logic        br_mispredict_i, mem_req_i, mem_ready_i;
    logic        pc_hold_o, pc_redirect_en_o, if_id_hold_o, if_id_flush_o;
    logic        id_ex_flush_o, id_ex_hold_o, ex_mem_hold_o, mem_wb_bubble_o, fault_o;
    logic [1:0]  state_o;
    logic [31:0] stall_cycles_o, flush_count_o;

    int passed = 0;
    int total  = 0;
    int model_stalls = 0;
    int model_flushes = 0;
    sb_t sbq[$];
    vec_t tbl[30];

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_rs1_addr_i    (id_rs1_addr_i),
        .id_rs2_addr_i    (id_rs2_addr_i),
        .id_rs1_used_i    (id_rs1_used_i),
        .id_rs2_used_i    (id_rs2_used_i),
        .ex_reg_wr_addr_i (ex_reg_wr_addr_i),
        .ex_reg_wr_sig_i  (ex_reg_wr_sig_i),
        .ex_is_load_i     (ex_is_load_i),
        .br_mispredict_i  (br_mispredict_i),
        .mem_req_i        (mem_req_i),
        .mem_ready_i      (mem_ready_i),
        .pc_hold_o        (pc_hold_o),
        .pc_redirect_en_o (pc_redirect_en_o),
        .if_id_hold_o     (if_id_hold_o),
        .if_id_flush_o    (if_id_flush_o),
        .id_ex_flush_o    (id_ex_flush_o),
        .id_ex_hold_o     (id_ex_hold_o),
        .ex_mem_hold_o    (ex_mem_hold_o),
        .mem_wb_bubble_o  (mem_wb_bubble_o),
        .fault_o          (fault_o),
        .state_o          (state_o),
        .stall_cycles_o   (stall_cycles_o),
        .flush_count_o    (flush_count_o)
    );

    function automatic vec_t mk(input logic rst, input logic [4:0] rs1, input logic rs1u,
                                input logic [4:0] rs2, input logic rs2u, input logic [4:0] exwa,
                                input logic exwr, input logic exld, input logic mis,
                                input logic req, input logic rdy, input logic [7:0] ctrl,
                                input logic [1:0] st, input logic fault);
        vec_t v;
        v.rst = rst;   v.rs1 = rs1;   v.rs1u = rs1u; v.rs2 = rs2;  v.rs2u = rs2u;
        v.exwa = exwa; v.exwr = exwr; v.exld = exld; v.mis = mis;  v.req = req;
        v.rdy = rdy;   v.ctrl = ctrl; v.st = st;     v.fault = fault;
        return v;
    endfunction

    function automatic vec_t mv(input logic req, input logic rdy, input logic mis,
                                input logic [7:0] ctrl, input logic [1:0] st, input logic fault);
        return mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, mis, req, rdy, ctrl, st, fault);
    endfunction

    task automatic apply(input vec_t t, input int idx);
        sb_t e;
        logic [10:0] act;
        reset            = t.rst;
        id_rs1_addr_i    = t.rs1;
        id_rs1_used_i    = t.rs1u;
        id_rs2_addr_i    = t.rs2;
        id_rs2_used_i    = t.rs2u;
        ex_reg_wr_addr_i = t.exwa;
        ex_reg_wr_sig_i  = t.exwr;
        ex_is_load_i     = t.exld;
        br_mispredict_i  = t.mis;
        mem_req_i        = t.req;
        mem_ready_i      = t.rdy;
        sbq.push_back('{exp: {t.ctrl, t.fault, t.st}, idx: idx});
        @(negedge clk);
        e   = sbq.pop_front();
        act = {pc_hold_o, pc_redirect_en_o, if_id_hold_o, if_id_flush_o, id_ex_flush_o,
               id_ex_hold_o, ex_mem_hold_o, mem_wb_bubble_o, fault_o, state_o};
        total++;
        if (act === e.exp) passed++;
        else $display("FAIL vec%0d: got ctrl/fault/state %b want %b", e.idx, act, e.exp);
        if (t.rst) begin
            model_stalls  = 0;
            model_flushes = 0;
        end else begin
            if ((t.ctrl & HOLD_MASK) != 8'd0) model_stalls++;
            if (t.ctrl[6]) model_flushes++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_perf(input string name);
        logic [31:0] exp_stall, exp_flush;
`ifdef HAZARD_PERF_CNT_EN
        exp_stall = 32'(model_stalls);
        exp_flush = 32'(model_flushes);
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        @(negedge clk);
        total++;
        if (stall_cycles_o === exp_stall) passed++;
        else $display("FAIL %s_stall: got %0d want %0d", name, stall_cycles_o, exp_stall);
        total++;
        if (flush_count_o === exp_flush) passed++;
        else $display("FAIL %s_flush: got %0d want %0d", name, flush_count_o, exp_flush);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        {id_rs1_addr_i, id_rs2_addr_i, ex_reg_wr_addr_i} = '0;
        {id_rs1_used_i, id_rs2_used_i, ex_reg_wr_sig_i, ex_is_load_i} = '0;
        {br_mispredict_i, mem_req_i, mem_ready_i} = '0;

        tbl[0]  = mk(1, 0,0, 0,0, 0,0,0, 0,0,0, C_RST,  0, 0);
        tbl[1]  = mk(1, 0,0, 0,0, 0,0,0, 1,1,0, C_RST,  0, 0);
        tbl[2]  = mv(0,0,0, C_NONE, 0, 0);
        tbl[3]  = mk(0, 5,1, 0,0, 5,1,1, 0,0,0, C_LU,   0, 0);
        tbl[4]  = mk(0, 5,1, 0,0, 0,0,0, 0,0,0, C_NONE, 0, 0);
        tbl[5]  = mk(0, 0,1, 0,0, 0,1,1, 0,0,0, C_NONE, 0, 0);
        tbl[6]  = mk(0, 3,1, 7,1, 7,1,1, 0,0,0, C_LU,   0, 0);
        tbl[7]  = mk(0, 3,1, 7,0, 7,1,1, 0,0,0, C_NONE, 0, 0);
        tbl[8]  = mk(0, 7,1, 0,0, 7,0,1, 0,0,0, C_NONE, 0, 0);
        tbl[9]  = mk(0, 7,1, 0,0, 7,1,0, 0,0,0, C_NONE, 0, 0);
        tbl[10] = mk(0, 5,1, 0,0, 5,1,1, 1,0,0, C_MIS,  0, 0);
        tbl[11] = mv(0,0,0, C_NONE, 0, 0);
        tbl[12] = mv(1,0,0, C_HOLD, 0, 0);
        tbl[13] = mv(1,0,0, C_HOLD, 1, 0);
        tbl[14] = mv(1,0,0, C_HOLD, 1, 0);
        tbl[15] = mv(1,1,0, C_NONE, 1, 0);
        tbl[16] = mv(0,0,0, C_NONE, 0, 0);
        tbl[17] = mv(1,0,1, C_HOLD, 0, 0);
        tbl[18] = mv(1,0,1, C_HOLD, 2, 0);
        tbl[19] = mv(1,1,1, C_MIS,  2, 0);
        tbl[20] = mv(0,0,0, C_NONE, 0, 0);
        tbl[21] = mv(1,0,0, C_HOLD, 0, 0);
        tbl[22] = mv(1,0,1, C_HOLD, 1, 0);
        tbl[23] = mk(0, 5,1, 0,0, 5,1,1, 1,1,0, C_HOLD, 2, 0);
        tbl[24] = mv(1,1,0, C_MIS,  2, 0);
        tbl[25] = mv(0,0,0, C_NONE, 0, 0);
        tbl[26] = mv(1,0,0, C_HOLD, 0, 0);
        tbl[27] = mv(1,0,0, C_HOLD, 1, 0);
        tbl[28] = mv(0,0,0, C_NONE, 1, 0);
        tbl[29] = mv(0,0,0, C_NONE, 0, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 30; i++) apply(tbl[i], i);

        // Timeout: one RUN stall, four MEM_WAIT cycles, then sticky FAULT.
        apply(mv(1,0,0, C_HOLD, 0, 0), 100);
        for (int i = 0; i < 4; i++) apply(mv(1,0,0, C_HOLD, 1, 0), 101 + i);
        apply(mv(1,0,0, C_HOLD, 3, 1), 105);
        apply(mv(1,1,0, C_HOLD, 3, 1), 106);
        apply(mv(0,0,1, C_HOLD, 3, 1), 107);
        apply(mk(1, 0,0, 0,0, 0,0,0, 0,0,0, C_RST, 0, 0), 108);
        apply(mv(0,0,0, C_NONE, 0, 0), 109);
        check_perf("after_reset");

        // Perf counters: two load-use stalls, a 3-cycle wait, one mispredict.
        apply(mk(0, 5,1, 0,0, 5,1,1, 0,0,0, C_LU, 0, 0), 200);
        apply(mv(0,0,0, C_NONE, 0, 0), 201);
        apply(mk(0, 0,0, 9,1, 9,1,1, 0,0,0, C_LU, 0, 0), 202);
        apply(mv(0,0,0, C_NONE, 0, 0), 203);
        apply(mv(1,0,0, C_HOLD, 0, 0), 204);
        apply(mv(1,0,0, C_HOLD, 1, 0), 205);
        apply(mv(1,0,0, C_HOLD, 1, 0), 206);
        apply(mv(1,1,0, C_NONE, 1, 0), 207);
        apply(mv(0,0,0, C_NONE, 0, 0), 208);
        apply(mv(0,0,1, C_MIS,  0, 0), 209);
        apply(mv(0,0,0, C_NONE, 0, 0), 210);
        check_perf("perf");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
